// File: rtl/rect_pkg.sv
// Shared constants and types for the rectangle list copier.
package rect_pkg;

    // Record layout in data memory: six 16-bit words per rectangle
    localparam int unsigned WORDS_PER_RECT = 6;
    localparam int unsigned OFF_WIDTH_BITS = 3;
    localparam int unsigned DATA_W         = 16;

    localparam logic [2:0] OFF_FLAGS  = 3'd0;
    localparam logic [2:0] OFF_X      = 3'd1;
    localparam logic [2:0] OFF_Y      = 3'd2;
    localparam logic [2:0] OFF_WIDTH  = 3'd3;
    localparam logic [2:0] OFF_HEIGHT = 3'd4;
    localparam logic [2:0] OFF_COLOR  = 3'd5;

    // Flag word bit positions; remaining bits are ignored
    localparam int unsigned ABS_BIT    = 0;
    localparam int unsigned HIDDEN_BIT = 1;

    // Visible screen area, only consulted when clipping is built in
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    // GPU buffer word packing, x in the least significant field
    localparam int unsigned WR_X_LSB    = 0;
    localparam int unsigned WR_Y_LSB    = 16;
    localparam int unsigned WR_W_LSB    = 32;
    localparam int unsigned WR_H_LSB    = 48;
    localparam int unsigned WR_C_LSB    = 64;
    localparam int unsigned WR_DATA_W   = 80;

    typedef struct packed {
        logic [15:0] color;
        logic [15:0] height;
        logic [15:0] width;
        logic [15:0] y;
        logic [15:0] x;
    } rect_word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/rect_list_copier_cursor.sv
// Running cursor and absolute/relative coordinate resolution.
module rect_cursor_unit #(
    parameter int unsigned COORD_WIDTH = 13
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   load_x,
    input  logic                   load_y,
    input  logic                   abs_flag,
    input  logic [COORD_WIDTH-1:0] field,
    output logic [COORD_WIDTH-1:0] res_x,
    output logic [COORD_WIDTH-1:0] res_y
);

    logic [COORD_WIDTH-1:0] cur_x;
    logic [COORD_WIDTH-1:0] cur_y;
    logic [COORD_WIDTH-1:0] resolved_c;

    // Resolve the incoming field against the cursor axis being loaded
    always_comb begin
        resolved_c = field;
        if (!abs_flag) begin
            resolved_c = (load_x ? cur_x : cur_y) + field;
        end
    end

    // Absolute records move the cursor even when hidden; relative ones never do
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_x <= '0;
            cur_y <= '0;
            res_x <= '0;
            res_y <= '0;
        end else if (clear) begin
            cur_x <= '0;
            cur_y <= '0;
        end else begin
            if (load_x) begin
                res_x <= resolved_c;
                if (abs_flag) begin
                    cur_x <= field;
                end
            end
            if (load_y) begin
                res_y <= resolved_c;
                if (abs_flag) begin
                    cur_y <= field;
                end
            end
        end
    end

endmodule

// File: rtl/rect_list_copier.sv
// Walks the rectangle list in data memory and writes visible rects, compacted,
// into the GPU rect buffer. Optional macro RECT_CLIP_EN drops rects whose
// resolved origin lies off screen.
module rect_list_copier
    import rect_pkg::*;
#(
    parameter int unsigned COORD_WIDTH = 13,
    parameter int unsigned ADDR_WIDTH  = 13,
    parameter int unsigned RECT_COUNT  = 64,
    parameter int unsigned RECT_ADDR   = 8192 - 6 * 64
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            copy_start,
    output logic                            busy,
    output logic                            done,
    output logic                            gpu_reset,
    output logic [ADDR_WIDTH-1:0]           mem_rd_addr,
    input  logic [15:0]                     mem_rd_data,
    output logic                            wr_en,
    output logic [$clog2(RECT_COUNT)-1:0]   wr_index,
    output logic [79:0]                     wr_data,
    output logic [$clog2(RECT_COUNT):0]     rect_count
);

    localparam int unsigned IDX_W   = $clog2(RECT_COUNT);
    localparam int unsigned CNT_W   = IDX_W + 1;
    localparam int unsigned N_WORDS = WORDS_PER_RECT * RECT_COUNT;
    localparam int unsigned RD_W    = $clog2(N_WORDS);

    state_t state;
    state_t state_nxt;

    logic accept_c;
    logic issue_c;
    logic last_issue_c;
    logic finish_c;

    logic [RD_W-1:0]  rd_cnt;
    logic [2:0]       iss_off;
    logic             ret_valid;
    logic [2:0]       ret_off;
    logic             abs_q;
    logic             hid_q;
    logic [COORD_WIDTH-1:0] w_q;
    logic [COORD_WIDTH-1:0] h_q;
    logic [CNT_W-1:0] slot;

    logic [COORD_WIDTH-1:0] field_c;
    logic [COORD_WIDTH-1:0] res_x;
    logic [COORD_WIDTH-1:0] res_y;
    logic       load_x_c;
    logic       load_y_c;
    logic       visible_c;
    logic       commit_c;
    rect_word_t commit_word_c;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (copy_start) state_nxt = FETCH;
            FETCH:   if (last_issue_c) state_nxt = DRAIN;
            DRAIN:   state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        accept_c     = 1'b0;
        issue_c      = 1'b0;
        finish_c     = 1'b0;
        case (state)
            IDLE:    accept_c = copy_start;
            FETCH:   issue_c  = 1'b1;
            FINISH:  finish_c = 1'b1;
            default: ;
        endcase
        last_issue_c = issue_c && (rd_cnt == RD_W'(N_WORDS - 1));
    end

    // Returned-word decode and commit decision
    always_comb begin
        field_c  = COORD_WIDTH'(mem_rd_data);
        load_x_c = ret_valid && (ret_off == OFF_X);
        load_y_c = ret_valid && (ret_off == OFF_Y);
`ifdef RECT_CLIP_EN
        visible_c = !hid_q && (32'(res_x) < SCREEN_W) && (32'(res_y) < SCREEN_H);
`else
        visible_c = !hid_q;
`endif
        commit_c             = ret_valid && (ret_off == OFF_COLOR) && visible_c;
        commit_word_c.color  = mem_rd_data;
        commit_word_c.height = 16'(h_q);
        commit_word_c.width  = 16'(w_q);
        commit_word_c.y      = 16'(res_y);
        commit_word_c.x      = 16'(res_x);
    end

    rect_cursor_unit #(
        .COORD_WIDTH (COORD_WIDTH)
    ) u_cursor (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (accept_c),
        .load_x   (load_x_c),
        .load_y   (load_y_c),
        .abs_flag (abs_q),
        .field    (field_c),
        .res_x    (res_x),
        .res_y    (res_y)
    );

    // Handshake outputs and read-address sequencing
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            gpu_reset   <= 1'b0;
            mem_rd_addr <= ADDR_WIDTH'(RECT_ADDR);
            rd_cnt      <= '0;
            iss_off     <= '0;
            ret_valid   <= 1'b0;
            ret_off     <= '0;
        end else begin
            gpu_reset <= accept_c;
            done      <= finish_c;
            ret_valid <= issue_c;
            ret_off   <= iss_off;
            if (accept_c) begin
                busy        <= 1'b1;
                mem_rd_addr <= ADDR_WIDTH'(RECT_ADDR);
                rd_cnt      <= '0;
                iss_off     <= '0;
            end else if (issue_c) begin
                rd_cnt      <= rd_cnt + RD_W'(1);
                iss_off     <= (iss_off == 3'(WORDS_PER_RECT - 1)) ? 3'd0 : iss_off + 3'd1;
                mem_rd_addr <= last_issue_c ? ADDR_WIDTH'(RECT_ADDR)
                                            : mem_rd_addr + ADDR_WIDTH'(1);
            end else if (finish_c) begin
                busy <= 1'b0;
            end
        end
    end

    // Field capture, compacted buffer writes and visible-count publication
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            abs_q      <= 1'b0;
            hid_q      <= 1'b0;
            w_q        <= '0;
            h_q        <= '0;
            slot       <= '0;
            wr_en      <= 1'b0;
            wr_index   <= '0;
            wr_data    <= '0;
            rect_count <= '0;
        end else begin
            wr_en <= commit_c;
            if (ret_valid) begin
                case (ret_off)
                    OFF_FLAGS: begin
                        abs_q <= mem_rd_data[ABS_BIT];
                        hid_q <= mem_rd_data[HIDDEN_BIT];
                    end
                    OFF_WIDTH:  w_q <= field_c;
                    OFF_HEIGHT: h_q <= field_c;
                    default: ;
                endcase
            end
            if (accept_c) begin
                slot <= '0;
            end else if (commit_c) begin
                wr_index <= slot[IDX_W-1:0];
                wr_data  <= commit_word_c;
                slot     <= slot + CNT_W'(1);
            end
            if (finish_c) begin
                rect_count <= slot;
            end
        end
    end

endmodule

// File: tb/tb_rect_list_copier.sv
// Randomized and directed bench for rect_list_copier with a list-level model.
module tb_rect_list_copier;

    localparam int RC    = 4;
    localparam int NW    = 6 * RC;
    localparam int RA    = 8192 - NW;
    localparam int CMOD  = 8192;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        copy_start = 1'b0;
    logic        busy, done, gpu_reset, wr_en;
    logic [12:0] mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic [1:0]  wr_index;
    logic [79:0] wr_data;
    logic [2:0]  rect_count;

    rect_list_copier #(
        .COORD_WIDTH (13),
        .ADDR_WIDTH  (13),
        .RECT_COUNT  (RC),
        .RECT_ADDR   (RA)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .copy_start  (copy_start),
        .busy        (busy),
        .done        (done),
        .gpu_reset   (gpu_reset),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .wr_en       (wr_en),
        .wr_index    (wr_index),
        .wr_data     (wr_data),
        .rect_count  (rect_count)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous read, one cycle latency
    logic [15:0] mem [0:8191];
    always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- list-level reference model ----------------
    typedef struct {
        int          rel;
        int          idx;
        logic [79:0] data;
    } wr_t;

    wr_t         expq[$];
    int          cyc = 0;
    bit          chk_en = 0;
    bit          run_active = 0;
    int          acc = 0;
    int          run_rc = 0;
    int          last_rc = 0;
    logic [79:0] seen [0:RC-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Expected writes from the list contents: cursor walk, hiding, compaction
    task automatic build_model();
        int cx, cy, slot, rx, ry, w, h, b;
        bit ab, hd, vis;
        wr_t e;
        cx = 0; cy = 0; slot = 0;
        expq.delete();
        for (int r = 0; r < RC; r++) begin
            b  = RA + 6 * r;
            ab = mem[b][0];
            hd = mem[b][1];
            rx = int'(mem[b + 1]) % CMOD;
            ry = int'(mem[b + 2]) % CMOD;
            if (ab) begin
                cx = rx; cy = ry;
            end else begin
                rx = (cx + rx) % CMOD;
                ry = (cy + ry) % CMOD;
            end
            w = int'(mem[b + 3]) % CMOD;
            h = int'(mem[b + 4]) % CMOD;
            vis = !hd;
`ifdef RECT_CLIP_EN
            if (rx >= 640 || ry >= 480) vis = 0;
`endif
            if (vis) begin
                e.rel  = 6 * r + 8;
                e.idx  = slot;
                e.data = {mem[b + 5], 16'(h), 16'(w), 16'(ry), 16'(rx)};
                expq.push_back(e);
                slot++;
            end
        end
        run_rc = slot;
    endtask

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        int  rel;
        bit  e_busy, e_done, e_gr, e_wr;
        int  e_rc;
        rel = run_active ? (cyc - acc) : -1;
        if (chk_en) begin
            e_busy = run_active && rel >= 1 && rel <= NW + 2;
            e_done = run_active && rel == NW + 3;
            e_gr   = run_active && rel == 1;
            e_rc   = e_done ? run_rc : last_rc;
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("gpu_reset", gpu_reset, e_gr);
            check("rect_count", rect_count, e_rc);
            if (run_active && rel >= 1 && rel <= NW)
                check("rd_addr_fetch", mem_rd_addr, RA + rel - 1);
            else if (!run_active || rel >= NW + 3)
                check("rd_addr_idle", mem_rd_addr, RA);
            e_wr = run_active && expq.size() > 0 && expq[0].rel == rel;
            check("wr_en", wr_en, e_wr);
            if (e_wr) begin
                if (wr_en) begin
                    check("wr_index", wr_index, expq[0].idx);
                    check("wr_data", wr_data, expq[0].data);
                    seen[wr_index] = wr_data;
                end
                void'(expq.pop_front());
            end
        end
        if (run_active && rel == NW + 3) begin
            run_active = 0;
            last_rc = run_rc;
        end
        if (!reset_n) begin
            chk_en = 1;
            run_active = 0;
            expq.delete();
            last_rc = 0;
        end else if (!run_active && copy_start && chk_en) begin
            run_active = 1;
            acc = cyc;
            build_model();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_rec(input int r, input logic [15:0] f, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] w,
                           input logic [15:0] h, input logic [15:0] c);
        mem[RA + 6 * r + 0] = f;
        mem[RA + 6 * r + 1] = x;
        mem[RA + 6 * r + 2] = y;
        mem[RA + 6 * r + 3] = w;
        mem[RA + 6 * r + 4] = h;
        mem[RA + 6 * r + 5] = c;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < RC; i++) seen[i] = '1;
    endtask

    task automatic start_copy();
        @(posedge clk); #2 copy_start = 1'b1;
        @(posedge clk); #2 copy_start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #3;
            if (!run_active && !busy) break;
        end
        check("idle_reached", run_active, 0);
    endtask

    int lat, gr_cnt, dn_cnt, wr_cnt;

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0;
        clear_seen();
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #3;
        check("rst_busy", busy, 0);
        check("rst_addr", mem_rd_addr, RA);
        check("rst_rect_count", rect_count, 0);
        check("rst_wr_data", wr_data, 0);

        // Reset in the middle of rect 2 of the very first copy
        for (int r = 0; r < RC; r++) set_rec(r, 16'h1, 16'(r), 16'(r), 16'h1, 16'h1, 16'h77);
        start_copy();
        repeat (13) @(posedge clk);
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        wr_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #3;
            if (wr_en) wr_cnt++;
        end
        check("abort_no_writes", wr_cnt, 0);
        check("abort_busy", busy, 0);
        check("abort_rect_count", rect_count, 0);
        check("abort_addr", mem_rd_addr, RA);

        // All absolute, all visible; also measures done latency
        clear_seen();
        for (int r = 0; r < RC; r++)
            set_rec(r, 16'h1, 16'(10 * r), 16'(20 * r), 16'd5, 16'd6, 16'hF000 | 16'(r));
        start_copy();
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #3;
            lat++;
        end
        check("done_latency", lat, 27);
        wait_idle();
        check("abs_rect_count", rect_count, 4);
        check("abs_slot2", seen[2], {16'hF002, 16'd6, 16'd5, 16'd40, 16'd20});
        check("abs_slot3", seen[3], {16'hF003, 16'd6, 16'd5, 16'd60, 16'd30});

        // Relative offsets with wrap and field truncation
        clear_seen();
        set_rec(0, 16'h1, 16'd100, 16'd50, 16'd1, 16'd1, 16'h00A0);
        set_rec(1, 16'h0, 16'd7, 16'd3, 16'd1, 16'd1, 16'h00A1);
        set_rec(2, 16'h0, 16'h1FFF, 16'd0, 16'd1, 16'd1, 16'h00A2);
        set_rec(3, 16'hFFFC, 16'h2005, 16'h0001, 16'd1, 16'd1, 16'h00A3);
        start_copy();
        wait_idle();
        check("rel_slot1_xy", seen[1][31:0], {16'd53, 16'd107});
        check("rel_slot2_xy", seen[2][31:0], {16'd50, 16'd99});
        check("rel_slot3_xy", seen[3][31:0], {16'd51, 16'd105});

        // Hidden absolute record acts as an invisible anchor
        clear_seen();
        set_rec(0, 16'h1, 16'd0, 16'd0, 16'd1, 16'd1, 16'h00C0);
        set_rec(1, 16'h3, 16'd300, 16'd300, 16'd1, 16'd1, 16'h00C1);
        set_rec(2, 16'h0, 16'd1, 16'd1, 16'd2, 16'd3, 16'h00C2);
        set_rec(3, 16'h1, 16'd5, 16'd5, 16'd1, 16'd1, 16'h00C3);
        start_copy();
        wait_idle();
        check("anchor_rect_count", rect_count, 3);
        check("anchor_slot1", seen[1], {16'h00C2, 16'd3, 16'd2, 16'd301, 16'd301});

        // copy_start held then pulsed during a copy: no restart
        @(posedge clk); #2 copy_start = 1'b1;
        gr_cnt = 0; dn_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #3;
            if (gpu_reset) gr_cnt++;
            if (done) dn_cnt++;
            if (k == 10) copy_start = 1'b0;
            if (k == 15) copy_start = 1'b1;
            if (k == 16) copy_start = 1'b0;
        end
        check("held_gpu_reset_pulses", gr_cnt, 1);
        check("held_done_pulses", dn_cnt, 1);

        // Off-screen origin: clipped only when clipping is built in
        set_rec(0, 16'h1, 16'd640, 16'd10, 16'd1, 16'd1, 16'h00D0);
        set_rec(1, 16'h1, 16'd639, 16'd479, 16'd1, 16'd1, 16'h00D1);
        set_rec(2, 16'h0, 16'd0, 16'd0, 16'd1, 16'd1, 16'h00D2);
        set_rec(3, 16'h1, 16'd0, 16'd0, 16'd1, 16'd1, 16'h00D3);
        start_copy();
        wait_idle();
`ifdef RECT_CLIP_EN
        check("clip_rect_count", rect_count, 3);
`else
        check("clip_rect_count", rect_count, 4);
`endif

        // Randomized lists
        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < RC; r++)
                set_rec(r, 16'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                        16'($urandom), 16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            start_copy();
            wait_idle();
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
